// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared bus command encoding and responder defaults
package dmem_responder_pkg;

    // Encoding is shared with the dcache controller; code 3 is treated as no request.
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_t;

    localparam int DEFAULT_MEM_LATENCY = 4;
    localparam int DEFAULT_MEM_DEPTH   = 256;
    localparam int NUM_TAGS            = 15;

    typedef logic [3:0] tag_t;

    function automatic logic is_request(input logic [1:0] cmd);
        return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - processor-to-data-memory request/response bundle
interface dmem_if;
    logic [1:0]  proc2Dmem_command;
    logic [31:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic [3:0]  Dmem2proc_response;
    logic [63:0] Dmem2proc_data;
    logic [3:0]  Dmem2proc_tag;

    modport master (
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
    );

    modport slave (
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
    );
endinterface

// File: rtl/dmem_tag_pool.sv
// rtl/dmem_tag_pool.sv - lowest-free tag selection over the registered busy mask
module dmem_tag_pool
    import dmem_responder_pkg::*;
(
    input  logic [NUM_TAGS:1] busy,
    output tag_t              free_tag,
    output logic              full
);

    // Scanning downward leaves the lowest-numbered free tag as the final winner.
    always_comb begin
        free_tag = '0;
        for (int t = NUM_TAGS; t >= 1; t--) begin
            if (!busy[t]) free_tag = tag_t'(t);
        end
    end

    assign full = &busy;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency tagged data memory model with 15 outstanding tags
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int MEM_DEPTH   = DEFAULT_MEM_DEPTH
) (
    input logic   clock,
    input logic   reset,
    dmem_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [63:0]              mem [MEM_DEPTH];
    logic [3:0]               count [NUM_TAGS+1];
    logic [63:0]              payload [NUM_TAGS+1];
    logic [NUM_TAGS:0][1:0]   kind;
    logic [NUM_TAGS:1]        busy;
    tag_t                     free_tag;
    tag_t                     next_tag;
    tag_t                     tag_q;
    logic                     full;
    logic                     accept;
    logic [IDX_W-1:0]         idx;
    logic [63:0]              new_payload;
    logic [63:0]              next_data;
    logic [63:0]              data_q;
    logic                     unused;

    always_comb begin
        busy = '0;
        for (int t = 1; t <= NUM_TAGS; t++) busy[t] = (count[t] != 4'd0);
    end

    dmem_tag_pool u_tag_pool (
        .busy     (busy),
        .free_tag (free_tag),
        .full     (full)
    );

    assign accept      = reset && is_request(bus.proc2Dmem_command) && !full;
    assign idx         = bus.proc2Dmem_addr[3 +: IDX_W];
    assign new_payload = (bus.proc2Dmem_command == BUS_STORE) ? bus.proc2Dmem_data : mem[idx];

    assign bus.Dmem2proc_response = accept ? free_tag : 4'd0;
    assign bus.Dmem2proc_tag      = tag_q;
    assign bus.Dmem2proc_data     = data_q;

    // The output register is loaded one edge early: a countdown of 2 means "completes next cycle".
    always_comb begin
        next_tag  = '0;
        next_data = '0;
        if (MEM_LATENCY == 1) begin
            if (accept) begin
                next_tag  = free_tag;
                next_data = new_payload;
            end
        end else begin
            for (int t = 1; t <= NUM_TAGS; t++) begin
                if (count[t] == 4'd2) begin
                    next_tag  = tag_t'(t);
                    next_data = payload[t];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t <= NUM_TAGS; t++) begin
                count[t]   <= '0;
                payload[t] <= '0;
                kind[t]    <= BUS_NONE;
            end
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            for (int t = 1; t <= NUM_TAGS; t++) begin
                if (count[t] != 4'd0) count[t] <= count[t] - 4'd1;
            end
            if (accept) begin
                count[free_tag]   <= 4'(MEM_LATENCY);
                payload[free_tag] <= new_payload;
                kind[free_tag]    <= bus.proc2Dmem_command;
            end
            tag_q  <= next_tag;
            data_q <= next_data;
        end
    end

    // Backing store survives reset so software-visible memory persists across a core reset.
    always_ff @(posedge clock) begin
        if (accept && (bus.proc2Dmem_command == BUS_STORE)) mem[idx] <= bus.proc2Dmem_data;
    end

    assign unused = ^{bus.proc2Dmem_addr[2:0], bus.proc2Dmem_addr[31:3+IDX_W], kind};

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector table plus randomized run against a tag/due-cycle model
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int          LAT = DEFAULT_MEM_LATENCY;
    localparam logic [63:0] D   = 64'hDEAD_BEEF_0123_4567;
    localparam logic [1:0]  NO  = 2'd0;
    localparam logic [1:0]  LD  = 2'd1;
    localparam logic [1:0]  ST  = 2'd2;
    localparam logic [1:0]  C3  = 2'd3;

    logic clock;
    logic reset;
    dmem_if bus();

    dmem_responder #(.MEM_LATENCY(LAT), .MEM_DEPTH(256)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] ref_mem    [256];
    bit          ref_known  [256];
    bit          pend_v     [16];
    int          pend_due   [16];
    logic [63:0] pend_data  [16];
    bit          pend_known [16];

    function automatic void add(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                                input logic [3:0] r, input logic [3:0] t, input logic [63:0] rd);
        vec_t v;
        v.cmd = c; v.addr = a; v.data = d; v.resp = r; v.tag = t; v.rdata = rd;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // One bus cycle: drive at posedge+1, compare at negedge, advance the model for the edge.
    task automatic run_cycle(input logic rst_v, input bit has_exp, input vec_t v);
        logic [3:0]  m_resp;
        logic [3:0]  m_tag;
        logic [63:0] m_data;
        bit          m_known;
        int          idx;
        reset                 = rst_v;
        bus.proc2Dmem_command = v.cmd;
        bus.proc2Dmem_addr    = v.addr;
        bus.proc2Dmem_data    = v.data;
        if (!rst_v) for (int t = 0; t < 16; t++) pend_v[t] = 0;
        m_resp = 4'd0;
        if (rst_v && (v.cmd == LD || v.cmd == ST))
            for (int t = 15; t >= 1; t--) if (!pend_v[t]) m_resp = 4'(t);
        m_tag = 4'd0; m_data = 64'd0; m_known = 1;
        for (int t = 1; t < 16; t++) begin
            if (pend_v[t] && pend_due[t] == cyc) begin
                m_tag = 4'(t); m_data = pend_data[t]; m_known = pend_known[t];
            end
        end
        @(negedge clock);
        check("response", 64'(bus.Dmem2proc_response), 64'(m_resp));
        check("tag", 64'(bus.Dmem2proc_tag), 64'(m_tag));
        if (m_known) check("data", bus.Dmem2proc_data, m_data);
        if (has_exp) begin
            check("vec_response", 64'(bus.Dmem2proc_response), 64'(v.resp));
            check("vec_tag", 64'(bus.Dmem2proc_tag), 64'(v.tag));
            check("vec_data", bus.Dmem2proc_data, v.rdata);
        end
        if (m_tag != 0) pend_v[m_tag] = 0;
        if (m_resp != 0) begin
            idx = int'(v.addr[10:3]);
            if (v.cmd == ST) begin
                ref_mem[idx] = v.data; ref_known[idx] = 1;
                pend_data[m_resp] = v.data; pend_known[m_resp] = 1;
            end else begin
                pend_data[m_resp] = ref_mem[idx]; pend_known[m_resp] = ref_known[idx];
            end
            pend_v[m_resp]   = 1;
            pend_due[m_resp] = cyc + LAT;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic vec_t mk(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
        vec_t v;
        v.cmd = c; v.addr = a; v.data = d; v.resp = 4'd0; v.tag = 4'd0; v.rdata = 64'd0;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [1:0]  c;
        logic [31:0] a;
        int          sel;

        reset = 1'b1;
        bus.proc2Dmem_command = NO;
        bus.proc2Dmem_addr    = '0;
        bus.proc2Dmem_data    = '0;
        for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_known[i] = 0; end
        for (int t = 0; t < 16; t++) begin
            pend_v[t] = 0; pend_due[t] = 0; pend_data[t] = '0; pend_known[t] = 0;
        end

        // store/load/alias, illegal code, then tag 3 completing beside a new load
        add(ST, 32'h40,  D,     4'd1, 4'd0, 64'd0);
        add(LD, 32'h40,  64'd0, 4'd2, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd1, D);
        add(LD, 32'h840, 64'd0, 4'd1, 4'd2, D);
        add(C3, 32'h40,  64'd0, 4'd0, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd1, D);
        add(LD, 32'h40,  64'd0, 4'd1, 4'd0, 64'd0);
        add(LD, 32'h40,  64'd0, 4'd2, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd0, 64'd0);
        add(LD, 32'h40,  64'd0, 4'd3, 4'd1, D);
        add(LD, 32'h40,  64'd0, 4'd1, 4'd2, D);
        add(LD, 32'h40,  64'd0, 4'd2, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd0, 64'd0);
        add(LD, 32'h40,  64'd0, 4'd4, 4'd3, D);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd1, D);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd2, D);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd0, 64'd0);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd4, D);
        add(NO, 32'h0,   64'd0, 4'd0, 4'd0, 64'd0);

        @(posedge clock);
        #1;
        v = mk(LD, 32'h40, 64'd0);
        repeat (2) run_cycle(1'b0, 1'b1, v);

        foreach (vecs[i]) run_cycle(1'b1, 1'b1, vecs[i]);

        // three loads in flight when reset hits; none may complete, memory keeps D
        v = mk(LD, 32'h48, 64'd0); v.resp = 4'd1; run_cycle(1'b1, 1'b1, v);
        v = mk(LD, 32'h40, 64'd0); v.resp = 4'd2; run_cycle(1'b1, 1'b1, v);
        v = mk(LD, 32'h40, 64'd0); v.resp = 4'd3; run_cycle(1'b1, 1'b1, v);
        v = mk(LD, 32'h40, 64'd0); run_cycle(1'b0, 1'b1, v);
        v = mk(NO, 32'h0, 64'd0);  run_cycle(1'b0, 1'b1, v);
        v = mk(LD, 32'h40, 64'd0); v.resp = 4'd1; run_cycle(1'b1, 1'b1, v);
        v = mk(NO, 32'h0, 64'd0);
        repeat (3) run_cycle(1'b1, 1'b1, v);
        v.tag = 4'd1; v.rdata = D; run_cycle(1'b1, 1'b1, v);

        for (int i = 0; i < 16; i++) begin
            a = ($urandom & ~32'h7F8) | (32'(i) << 3);
            run_cycle(1'b1, 1'b0, mk(ST, a, {$urandom, $urandom}));
        end

        for (int i = 0; i < 24; i++) begin
            a = ($urandom & ~32'h7F8) | (32'($urandom_range(0, 15)) << 3);
            run_cycle(1'b1, 1'b0, mk(LD, a, 64'd0));
        end

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            c = (sel <= 3) ? LD : (sel <= 6) ? ST : (sel == 8) ? C3 : NO;
            a = ($urandom & ~32'h7F8) | (32'($urandom_range(0, 15)) << 3);
            run_cycle(($urandom_range(0, 79) != 0), 1'b0, mk(c, a, {$urandom, $urandom}));
        end

        repeat (LAT + 2) run_cycle(1'b1, 1'b0, mk(NO, 32'h0, 64'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
